// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port synchronous memory (1-cycle read latency)
//            between instruction fetch (I, read-only) and load/store (D).
//            Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR     = 16,
    parameter int WORD     = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    // instruction fetch requester
    input  logic            i_req,
    input  logic [ADDR-1:0] i_addr,
    input  logic            i_flush,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [WORD-1:0] i_rdata,
    // load/store requester
    input  logic            d_req,
    input  logic            d_we,
    input  logic [ADDR-1:0] d_addr,
    input  logic [WORD-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [WORD-1:0] d_rdata,
    // unified memory
    output logic [ADDR-1:0] mem_a,
    output logic            mem_w,
    output logic [WORD-1:0] mem_d,
    input  logic [WORD-1:0] mem_q
);

    // A zero wait limit would leave the guard counter without any bits.
    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("mem_arbiter: MAX_WAIT must be at least 1");
    end

    logic            w_i_gnt;
    logic            w_d_gnt;
    logic            w_i_rvalid;
    logic            w_d_rvalid;
    logic            r_pend_i;
    logic            r_pend_d;
    logic [WORD-1:0] r_i_rdata;
    logic [WORD-1:0] r_d_rdata;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int c_cnt_w = $clog2(MAX_WAIT + 1);

    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               w_force_i;

    // Once fetch has waited MAX_WAIT cycles it takes this cycle; D keeps its request held.
    assign w_force_i = (r_wait_cnt == c_cnt_w'(MAX_WAIT)) & i_req & ~i_flush;
    assign w_d_gnt   = d_req & ~w_force_i;
    assign w_i_gnt   = i_req & ~i_flush & (~d_req | w_force_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (w_i_gnt || !i_req) begin
            r_wait_cnt <= '0;
        end else if (!i_flush && (r_wait_cnt != c_cnt_w'(MAX_WAIT))) begin
            r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
        end
    end
`else
    assign w_d_gnt = d_req;
    assign w_i_gnt = i_req & ~d_req & ~i_flush;
`endif

    assign i_gnt = w_i_gnt;
    assign d_gnt = w_d_gnt;

    assign mem_a = w_d_gnt ? d_addr : (w_i_gnt ? i_addr : '0);
    assign mem_w = w_d_gnt & d_we;
    assign mem_d = w_d_gnt ? d_wdata : '0;

    // Stores finish at grant, so only loads leave a response pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_i <= 1'b0;
            r_pend_d <= 1'b0;
        end else begin
            r_pend_i <= w_i_gnt;
            r_pend_d <= w_d_gnt & ~d_we;
        end
    end

    // A response due in the reset cycle is dropped along with the pend state.
    assign w_i_rvalid = r_pend_i & ~i_flush & ~rst;
    assign w_d_rvalid = r_pend_d & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_i_rvalid) begin
                r_i_rdata <= mem_q;
            end
            if (w_d_rvalid) begin
                r_d_rdata <= mem_q;
            end
        end
    end

    assign i_rvalid = w_i_rvalid;
    assign d_rvalid = w_d_rvalid;
    assign i_rdata  = w_i_rvalid ? mem_q : r_i_rdata;
    assign d_rdata  = w_d_rvalid ? mem_q : r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with a behavioural memory and
//            a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR = 16;
    localparam int WORD = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_req, i_flush, i_gnt, i_rvalid;
    logic [ADDR-1:0] i_addr;
    logic [WORD-1:0] i_rdata;
    logic            d_req, d_we, d_gnt, d_rvalid;
    logic [ADDR-1:0] d_addr;
    logic [WORD-1:0] d_wdata, d_rdata;
    logic [ADDR-1:0] mem_a;
    logic            mem_w;
    logic [WORD-1:0] mem_d;
    logic [WORD-1:0] mem_q;

    logic [WORD-1:0] mem [0:(1<<ADDR)-1];

    typedef struct {
        int              due;
        logic [WORD-1:0] data;
    } exp_t;

    exp_t i_q[$];
    exp_t d_q[$];

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port synchronous memory, read-before-write, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_w) mem[mem_a] <= mem_d;
        mem_q <= mem[mem_a];
    end

    mem_arbiter #(.ADDR(ADDR), .WORD(WORD), .MAX_WAIT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_flush  (i_flush),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_a    (mem_a),
        .mem_w    (mem_w),
        .mem_d    (mem_d),
        .mem_q    (mem_q)
    );

    // Response monitor: every due entry must appear exactly in its cycle, nothing else may.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            n_checks++;
            if (i_q.size() > 0 && i_q[0].due == cyc) begin
                exp_t e;
                e = i_q.pop_front();
                if (i_rvalid !== 1'b1 || i_rdata !== e.data) begin
                    n_errors++;
                    $display("FAIL i_resp cyc=%0d: rvalid=%b rdata=%h, required rvalid=1 rdata=%h",
                             cyc, i_rvalid, i_rdata, e.data);
                end
            end else if (i_rvalid !== 1'b0) begin
                n_errors++;
                $display("FAIL i_unexpected cyc=%0d: rvalid=%b, required 0", cyc, i_rvalid);
            end
            n_checks++;
            if (d_q.size() > 0 && d_q[0].due == cyc) begin
                exp_t e;
                e = d_q.pop_front();
                if (d_rvalid !== 1'b1 || d_rdata !== e.data) begin
                    n_errors++;
                    $display("FAIL d_resp cyc=%0d: rvalid=%b rdata=%h, required rvalid=1 rdata=%h",
                             cyc, d_rvalid, d_rdata, e.data);
                end
            end else if (d_rvalid !== 1'b0) begin
                n_errors++;
                $display("FAIL d_unexpected cyc=%0d: rvalid=%b, required 0", cyc, d_rvalid);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_req   = 1'b0;
        i_flush = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
    endtask

    task automatic push_i(input logic [WORD-1:0] v);
        i_q.push_back('{due: cyc + 1, data: v});
    endtask

    task automatic push_d(input logic [WORD-1:0] v);
        d_q.push_back('{due: cyc + 1, data: v});
    endtask

    task automatic mem_store(input logic [ADDR-1:0] a, input logic [WORD-1:0] v);
        next_cycle();
        idle();
        d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = v;
        next_cycle();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        i_addr = '0; d_addr = '0; d_wdata = '0;
        @(negedge clk);
        n_checks++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || mem_w !== 1'b0 || mem_a !== '0) begin
            n_errors++;
            $display("FAIL reset_ctrl: i_rvalid=%b d_rvalid=%b mem_w=%b mem_a=%h, required 0 0 0 0000",
                     i_rvalid, d_rvalid, mem_w, mem_a);
        end
        n_checks++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            n_errors++;
            $display("FAIL reset_data: i_rdata=%h d_rdata=%h, required 0", i_rdata, d_rdata);
        end
        next_cycle();
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (i_rdata !== '0 || d_rdata !== '0 || i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset: i_rdata=%h d_rdata=%h i_gnt=%b d_gnt=%b, required 0 0 0 0",
                     i_rdata, d_rdata, i_gnt, d_gnt);
        end
    endtask

    task automatic test_single_fetch();
        next_cycle();
        i_req = 1'b1; i_addr = 16'h0010;
        @(negedge clk);
        n_checks++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_a !== 16'h0010 || mem_w !== 1'b0) begin
            n_errors++;
            $display("FAIL fetch_grant: i_gnt=%b d_gnt=%b mem_a=%h mem_w=%b, required 1 0 0010 0",
                     i_gnt, d_gnt, mem_a, mem_w);
        end
        push_i(32'hDEADBEEF);
        next_cycle();
        idle();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (i_rvalid !== 1'b0 || i_rdata !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL fetch_hold: i_rvalid=%b i_rdata=%h, required 0 deadbeef", i_rvalid, i_rdata);
        end
    endtask

    task automatic test_contention();
        next_cycle();
        i_req = 1'b1; i_addr = 16'h0020;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
        @(negedge clk);
        n_checks++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || mem_a !== 16'h0100) begin
            n_errors++;
            $display("FAIL contend_c0: d_gnt=%b i_gnt=%b mem_a=%h, required 1 0 0100", d_gnt, i_gnt, mem_a);
        end
        push_d(32'h12345678);
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (i_gnt !== 1'b1 || mem_a !== 16'h0020 || d_rvalid !== 1'b1 || d_rdata !== 32'h12345678) begin
            n_errors++;
            $display("FAIL contend_c1: i_gnt=%b mem_a=%h d_rvalid=%b d_rdata=%h, required 1 0020 1 12345678",
                     i_gnt, mem_a, d_rvalid, d_rdata);
        end
        push_i(32'hCAFEF00D);
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_store_load();
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        n_checks++;
        if (d_gnt !== 1'b1 || mem_w !== 1'b1 || mem_a !== 16'h0200 || mem_d !== 32'hA5A5A5A5) begin
            n_errors++;
            $display("FAIL store: d_gnt=%b mem_w=%b mem_a=%h mem_d=%h, required 1 1 0200 a5a5a5a5",
                     d_gnt, mem_w, mem_a, mem_d);
        end
        next_cycle();
        d_we = 1'b0; d_wdata = 32'h0;
        @(negedge clk);
        n_checks++;
        if (mem_w !== 1'b0 || d_rvalid !== 1'b0 || mem_d !== 32'h0) begin
            n_errors++;
            $display("FAIL load_issue: mem_w=%b d_rvalid=%b mem_d=%h, required 0 0 0", mem_w, d_rvalid, mem_d);
        end
        push_d(32'hA5A5A5A5);
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if (d_rdata !== 32'hA5A5A5A5 || mem_w !== 1'b0 || mem_a !== '0) begin
            n_errors++;
            $display("FAIL load_data: d_rdata=%h mem_w=%b mem_a=%h, required a5a5a5a5 0 0000",
                     d_rdata, mem_w, mem_a);
        end
    endtask

    task automatic test_flush();
        next_cycle();
        i_req = 1'b1; i_addr = 16'h0030;
        @(negedge clk);
        n_checks++;
        if (i_gnt !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_c0: i_gnt=%b, required 1", i_gnt);
        end
        next_cycle();
        i_flush = 1'b1; i_addr = 16'h0034;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
        @(negedge clk);
        n_checks++;
        if (i_gnt !== 1'b0 || i_rvalid !== 1'b0 || d_gnt !== 1'b1 || mem_a !== 16'h0100) begin
            n_errors++;
            $display("FAIL flush_c1: i_gnt=%b i_rvalid=%b d_gnt=%b mem_a=%h, required 0 0 1 0100",
                     i_gnt, i_rvalid, d_gnt, mem_a);
        end
        push_d(32'h12345678);
        next_cycle();
        i_flush = 1'b0; d_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (i_gnt !== 1'b1 || mem_a !== 16'h0034) begin
            n_errors++;
            $display("FAIL flush_c2: i_gnt=%b mem_a=%h, required 1 0034", i_gnt, mem_a);
        end
        push_i(32'h33334444);
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        bit              is_d [8] = '{1, 0, 1, 0, 0, 0, 1, 1};
        logic [ADDR-1:0] addr [8] = '{16'h0100, 16'h0010, 16'h0200, 16'h0020,
                                      16'h0030, 16'h0034, 16'h0100, 16'h0200};
        logic [WORD-1:0] data [8] = '{32'h12345678, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hCAFEF00D,
                                      32'h11112222, 32'h33334444, 32'h12345678, 32'hA5A5A5A5};
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            idle();
            if (is_d[k]) begin
                d_req = 1'b1; d_addr = addr[k];
            end else begin
                i_req = 1'b1; i_addr = addr[k];
            end
            @(negedge clk);
            n_checks++;
            if (i_gnt !== !is_d[k] || d_gnt !== is_d[k] || mem_a !== addr[k]) begin
                n_errors++;
                $display("FAIL b2b[%0d]: i_gnt=%b d_gnt=%b mem_a=%h, required %b %b %h",
                         k, i_gnt, d_gnt, mem_a, !is_d[k], is_d[k], addr[k]);
            end
            if (is_d[k]) push_d(data[k]);
            else         push_i(data[k]);
        end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_starvation();
        bit exp_i;
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0300; d_wdata = 32'h0BAD0BAD;
        i_req = 1'b1; i_addr = 16'h0010;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) next_cycle();
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_i = (k == 4);
`else
            exp_i = 1'b0;
`endif
            @(negedge clk);
            n_checks++;
            if (i_gnt !== exp_i || d_gnt !== !exp_i || mem_w !== !exp_i) begin
                n_errors++;
                $display("FAIL starve[%0d]: i_gnt=%b d_gnt=%b mem_w=%b, required %b %b %b",
                         k, i_gnt, d_gnt, mem_w, exp_i, !exp_i, !exp_i);
            end
            if (exp_i) begin
                n_checks++;
                if (mem_a !== 16'h0010) begin
                    n_errors++;
                    $display("FAIL starve_addr: mem_a=%h, required 0010", mem_a);
                end
                push_i(32'hDEADBEEF);
            end
        end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_reset_midop();
        next_cycle();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
        @(negedge clk);
        n_checks++;
        if (d_gnt !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid_gnt: d_gnt=%b, required 1", d_gnt);
        end
        next_cycle();
        d_req = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (d_rvalid !== 1'b0 || d_rdata !== '0 || i_rdata !== '0) begin
            n_errors++;
            $display("FAIL rst_mid_after: d_rvalid=%b d_rdata=%h i_rdata=%h, required 0 0 0",
                     d_rvalid, d_rdata, i_rdata);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0 || d_rdata !== '0) begin
            n_errors++;
            $display("FAIL rst_mid_quiet: d_rvalid=%b i_rvalid=%b d_rdata=%h, required 0 0 0",
                     d_rvalid, i_rvalid, d_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        mem_store(16'h0010, 32'hDEADBEEF);
        mem_store(16'h0020, 32'hCAFEF00D);
        mem_store(16'h0100, 32'h12345678);
        mem_store(16'h0030, 32'h11112222);
        mem_store(16'h0034, 32'h33334444);
        test_single_fetch();
        test_contention();
        test_store_load();
        test_flush();
        test_back_to_back();
        test_starvation();
        test_reset_midop();
        next_cycle();
        n_checks++;
        if (i_q.size() != 0 || d_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: i_q=%0d d_q=%0d left, required 0 0", i_q.size(), d_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
